call_stack: RTL and testbench

Hardware return-address stack serving the controller's `push`, `pop` and `RET` strobes. On a call it captures the return address from the datapath. On a return it presents the most recent saved address to the PC-select mux in the same cycle. It also tracks occupancy and latches sticky overflow and underflow errors for debug readout. It sits beside the PC register and is the responder end of the controller's call/return interface.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/stack_mem.sv | 31 +++
 rtl/call_stack.sv | 107 ++++++++++
 tb/tb_call_stack.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and call/return stack operation decode.
// Reused by the PC, controller and return-address stack.
package cpu_pkg;

    localparam int unsigned ADDR_W    = 12;
    localparam int unsigned RAS_DEPTH = 8;

    typedef enum logic [1:0] {
        OP_IDLE    = 2'b00,
        OP_POP     = 2'b01,
        OP_PUSH    = 2'b10,
        OP_REPLACE = 2'b11
    } stack_op_e;

    function automatic stack_op_e decodeOp(input logic push, input logic pop);
        return stack_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/stack_mem.sv
// DEPTH x AW register file: one synchronous write port, one asynchronous read port.
// All entries clear to zero on reset.
module stack_mem #(
    parameter int unsigned DEPTH = cpu_pkg::RAS_DEPTH,
    parameter int unsigned AW    = cpu_pkg::ADDR_W,
    localparam int unsigned IW   = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          writeEnable,
    input  logic [IW-1:0] writeIndex,
    input  logic [AW-1:0] writeData,
    input  logic [IW-1:0] readIndex,
    output logic [AW-1:0] readData
);

    logic [AW-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (writeEnable) begin
            mem[writeIndex] <= writeData;
        end
    end

    assign readData = mem[readIndex];

endmodule

// File: rtl/call_stack.sv
// Return-address stack: pointer/occupancy logic, sticky error flags and top decode.
// The top entry is combinational from state so a return completes in one cycle.
module call_stack
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = RAS_DEPTH,
    parameter int unsigned AW    = ADDR_W,
    localparam int unsigned IW   = $clog2(DEPTH),
    localparam int unsigned PW   = IW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] pushAddress,
    input  logic          clearErrors,
    output logic [AW-1:0] topAddress,
    output logic          empty,
    output logic          full,
    output logic [PW-1:0] depthCount,
    output logic          overflow,
    output logic          underflow
);

    logic [PW-1:0] sp;
    logic [PW-1:0] spNext;
    logic [PW-1:0] spDec;
    logic          isEmpty;
    logic          isFull;
    logic          writeEnable;
    logic [IW-1:0] writeIndex;
    logic          overflowEvent;
    logic          underflowEvent;
    logic [AW-1:0] readData;

    assign spDec   = sp - PW'(1);
    assign isEmpty = (sp == '0);
    assign isFull  = (sp == PW'(DEPTH));

    always_comb begin
        spNext         = sp;
        writeEnable    = 1'b0;
        writeIndex     = sp[IW-1:0];
        overflowEvent  = 1'b0;
        underflowEvent = 1'b0;
        unique case (decodeOp(push, pop))
            OP_PUSH: begin
                if (isFull) begin
                    overflowEvent = 1'b1;
                end else begin
                    writeEnable = 1'b1;
                    spNext      = sp + PW'(1);
                end
            end
            OP_POP: begin
                if (isEmpty) begin
                    underflowEvent = 1'b1;
                end else begin
                    spNext = spDec;
                end
            end
            // Simultaneous call/return replaces the top; on an empty stack it degrades to a push.
            OP_REPLACE: begin
                writeEnable = 1'b1;
                if (isEmpty) begin
                    writeIndex     = '0;
                    spNext         = PW'(1);
                    underflowEvent = 1'b1;
                end else begin
                    writeIndex = spDec[IW-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp        <= spNext;
            overflow  <= overflowEvent  | (overflow  & ~clearErrors);
            underflow <= underflowEvent | (underflow & ~clearErrors);
        end
    end

    stack_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_stack_mem (
        .clock       (clock),
        .reset       (reset),
        .writeEnable (writeEnable),
        .writeIndex  (writeIndex),
        .writeData   (pushAddress),
        .readIndex   (spDec[IW-1:0]),
        .readData    (readData)
    );

    assign topAddress = isEmpty ? '0 : readData;
    assign empty      = isEmpty;
    assign full       = isFull;
    assign depthCount = sp;

endmodule

// File: tb/tb_call_stack.sv
// Bench for call_stack: directed scenarios plus random strobes, checked against a
// queue-based model of a saturating LIFO with sticky error flags.
module tb_call_stack;

    localparam int DEPTH = 8;
    localparam int AW    = 12;
    localparam int PW    = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [AW-1:0] pushAddress = '0;
    logic          clearErrors = 1'b0;
    logic [AW-1:0] topAddress;
    logic          empty;
    logic          full;
    logic [PW-1:0] depthCount;
    logic          overflow;
    logic          underflow;

    always #5 clock = ~clock;

    call_stack #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .push        (push),
        .pop         (pop),
        .pushAddress (pushAddress),
        .clearErrors (clearErrors),
        .topAddress  (topAddress),
        .empty       (empty),
        .full        (full),
        .depthCount  (depthCount),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    int unsigned   passCount  = 0;
    int unsigned   checkCount = 0;
    logic [AW-1:0] model [$];
    logic          mOverflow  = 1'b0;
    logic          mUnderflow = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) begin
            passCount++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] modelTop();
        return (model.size() != 0) ? model[model.size() - 1] : '0;
    endfunction

    task automatic modelStep(input logic p, input logic po, input logic [AW-1:0] a,
                             input logic clr, input logic rst);
        logic ovfEvt;
        logic unfEvt;
        ovfEvt = 1'b0;
        unfEvt = 1'b0;
        if (rst) begin
            model.delete();
            mOverflow  = 1'b0;
            mUnderflow = 1'b0;
        end else begin
            if (p && po) begin
                if (model.size() == 0) begin
                    model.push_back(a);
                    unfEvt = 1'b1;
                end else begin
                    model[model.size() - 1] = a;
                end
            end else if (p) begin
                if (model.size() < DEPTH) model.push_back(a);
                else ovfEvt = 1'b1;
            end else if (po) begin
                if (model.size() > 0) void'(model.pop_back());
                else unfEvt = 1'b1;
            end
            mOverflow  = ovfEvt | (mOverflow & ~clr);
            mUnderflow = unfEvt | (mUnderflow & ~clr);
        end
    endtask

    task automatic checkModel(input string ctx);
        check({ctx, ".top"},       32'(topAddress), 32'(modelTop()));
        check({ctx, ".depth"},     32'(depthCount), 32'(model.size()));
        check({ctx, ".empty"},     32'(empty),      32'(model.size() == 0));
        check({ctx, ".full"},      32'(full),       32'(model.size() == DEPTH));
        check({ctx, ".overflow"},  32'(overflow),   32'(mOverflow));
        check({ctx, ".underflow"}, 32'(underflow),  32'(mUnderflow));
    endtask

    // One clock cycle: drive after the falling edge, check the top is stable
    // while strobes are pending, then compare all outputs just after the rising edge.
    task automatic step(input logic p, input logic po, input logic [AW-1:0] a,
                        input logic clr, input logic rst, input string ctx);
        @(negedge clock);
        push        = p;
        pop         = po;
        pushAddress = a;
        clearErrors = clr;
        reset       = rst;
        #1;
        check({ctx, ".preTop"}, 32'(topAddress), 32'(modelTop()));
        @(posedge clock);
        #1;
        modelStep(p, po, a, clr, rst);
        checkModel(ctx);
        push        = 1'b0;
        pop         = 1'b0;
        clearErrors = 1'b0;
        reset       = 1'b0;
    endtask

    initial begin
        step(0, 0, '0, 0, 1, "reset");
        check("reset.topConst", 32'(topAddress), 32'h0);
        check("reset.emptyConst", 32'(empty), 32'h1);

        step(1, 0, 12'h010, 0, 0, "p1.push");
        step(1, 0, 12'h020, 0, 0, "p1.push");
        step(1, 0, 12'h030, 0, 0, "p1.push");
        check("p1.depth3", 32'(depthCount), 32'd3);
        check("p1.top030", 32'(topAddress), 32'h030);
        step(0, 1, '0, 0, 0, "p1.pop");
        check("p1.top020", 32'(topAddress), 32'h020);
        step(0, 1, '0, 0, 0, "p1.pop");
        check("p1.top010", 32'(topAddress), 32'h010);
        step(0, 1, '0, 0, 0, "p1.pop");
        check("p1.top000", 32'(topAddress), 32'h000);
        check("p1.empty", 32'(empty), 32'h1);

        for (int i = 0; i < DEPTH; i++) step(1, 0, AW'(12'h100 + i), 0, 0, "p2.fill");
        step(1, 0, 12'habc, 0, 0, "p2.ovf");
        check("p2.full", 32'(full), 32'h1);
        check("p2.overflow", 32'(overflow), 32'h1);
        check("p2.top107", 32'(topAddress), 32'h107);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            check("p2.popTop", 32'(topAddress), 32'(12'h100 + i));
            step(0, 1, '0, 0, 0, "p2.drain");
        end

        step(0, 1, '0, 0, 0, "p3.unf");
        check("p3.underflow", 32'(underflow), 32'h1);
        step(0, 0, '0, 1, 0, "p3.clear");
        check("p3.cleared", 32'({overflow, underflow}), 32'h0);

        step(1, 0, 12'h011, 0, 0, "p4.push");
        step(1, 0, 12'h055, 0, 0, "p4.push");
        step(1, 1, 12'h077, 0, 0, "p4.replace");
        check("p4.depth2", 32'(depthCount), 32'd2);
        check("p4.top077", 32'(topAddress), 32'h077);
        check("p4.noFlags", 32'({overflow, underflow}), 32'h0);
        step(0, 0, '0, 0, 1, "p4.reset");
        step(1, 1, 12'h077, 0, 0, "p4.replaceEmpty");
        check("p4.emptyDepth1", 32'(depthCount), 32'd1);
        check("p4.emptyUnf", 32'(underflow), 32'h1);

        for (int i = 0; i < DEPTH; i++) step(1, 0, AW'(12'h200 + i), 0, 0, "p5.fill");
        step(1, 0, 12'h3ff, 1, 0, "p5.clrOvf");
        check("p5.ovfWins", 32'(overflow), 32'h1);

        step(0, 0, '0, 0, 1, "p6.reset");
        for (int i = 0; i < 5; i++) step(1, 0, AW'(12'h300 + i), 0, 0, "p6.fill");
        step(1, 0, 12'h3aa, 0, 1, "p6.resetPush");
        check("p6.depth0", 32'(depthCount), 32'd0);
        step(0, 1, '0, 0, 0, "p6.pop");
        check("p6.underflow", 32'(underflow), 32'h1);

        for (int i = 0; i < 400; i++) begin
            logic p, po, clr, rst;
            rst = ($urandom_range(0, 99) < 2);
            clr = ($urandom_range(0, 9) == 0);
            p   = (i < 200) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) < 4);
            po  = ($urandom_range(0, 1) == 1);
            step(p, po, AW'($urandom), clr, rst, "rand");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
